// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Holds the FSM state type and oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every CLK_DIV clocks.
// clr restarts the count so the bit phase aligns to a start edge.
module uart_baud_tick #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running divider, restarted by clr.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled, 8 data bits, one stop bit.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_DIV     = 27,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rd,
    output logic [7:0] data,
    output logic       rdf,
    output logic       rdc,
    output logic       error
);

    uart_state_t state;
    uart_state_t state_n;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;
    logic                   tick;
    logic [3:0]             os_cnt;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_q;
    logic                   accept_q;
    logic                   ferr_q;
    logic                   par_ok;
    logic                   os_last;
    logic                   sample;
    logic                   start_go;
    logic                   stop_hit;

    assign rxd_s = sync_q[SYNC_STAGES-1];

    // Metastability guard on the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_go),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and bit-sample strobes.
    always_comb begin
        state_n  = state;
        start_go = 1'b0;
        stop_hit = 1'b0;
        os_last  = (state == START) ? (os_cnt == 4'(MID_SAMPLE - 1))
                                    : (os_cnt == 4'(OVERSAMPLE - 1));
        sample   = tick && os_last;
        unique case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_n  = START;
                    start_go = 1'b1;
                end
            end
            START: begin
                if (sample) begin
                    state_n = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample && bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (sample) begin
                    state_n = STOP;
                end
`else
                state_n = IDLE;
`endif
            end
            STOP: begin
                if (sample) begin
                    state_n  = IDLE;
                    stop_hit = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic perr_q;

    // Even parity over data plus parity bit must xor to zero.
    always_ff @(posedge clk) begin
        if (rst || start_go) begin
            perr_q <= 1'b0;
        end else if (sample && state == PARITY) begin
            perr_q <= ^{shift_q, rxd_s};
        end
    end

    assign par_ok = ~perr_q;
`else
    assign par_ok = 1'b1;
`endif

    // Oversample/bit counters, data shift and stop verdict.
    always_ff @(posedge clk) begin
        if (rst) begin
            os_cnt   <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            accept_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            accept_q <= 1'b0;
            ferr_q   <= 1'b0;
            if (start_go) begin
                os_cnt  <= '0;
                bit_cnt <= '0;
            end else if (tick) begin
                os_cnt <= sample ? 4'd0 : os_cnt + 4'd1;
            end
            if (sample && state == DATA) begin
                shift_q <= {rxd_s, shift_q[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (stop_hit) begin
                if (rxd_s && par_ok) begin
                    accept_q <= 1'b1;
                end else begin
                    ferr_q <= 1'b1;
                end
            end
        end
    end

    // Consumer-facing holding register and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= 8'h00;
            rdf   <= 1'b0;
            rdc   <= 1'b0;
            error <= 1'b0;
        end else begin
            rdc <= 1'b0;
            if (accept_q) begin
                if (rdf && !rd) begin
                    error <= 1'b1;
                end else begin
                    data <= shift_q;
                    rdf  <= 1'b1;
                    rdc  <= 1'b1;
                    if (rd) begin
                        error <= 1'b0;
                    end
                end
            end else if (ferr_q) begin
                error <= 1'b1;
                if (rd) begin
                    rdf <= 1'b0;
                end
            end else if (rd) begin
                rdf   <= 1'b0;
                error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed and randomized frames against a frame-level receiver model.
// Parity checks are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int BIT     = 16 * CLK_DIV;
    localparam int LOW_STP = BIT * 5 / 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rd  = 1'b0;
    logic [7:0] data;
    logic       rdf;
    logic       rdc;
    logic       error;

    int checks  = 0;
    int errors  = 0;
    int rdc_cnt = 0;

    logic [7:0] m_data = 8'h00;
    logic       m_rdf  = 1'b0;
    logic       m_err  = 1'b0;
    int         m_rdc  = 0;

    uart_rx_core #(
        .CLK_DIV     (CLK_DIV),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .rd    (rd),
        .data  (data),
        .rdf   (rdf),
        .rdc   (rdc),
        .error (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rdc) rdc_cnt <= rdc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_data"}, 32'(data), 32'(m_data));
        check({tag, "_rdf"}, 32'(rdf), 32'(m_rdf));
        check({tag, "_err"}, 32'(error), 32'(m_err));
        check({tag, "_rdc"}, 32'(rdc_cnt), 32'(m_rdc));
    endtask

    function automatic void m_frame(input logic [7:0] b, input bit stop,
                                    input bit par_ok);
        if (!stop || !par_ok) begin
            m_err = 1'b1;
        end else if (m_rdf) begin
            m_err = 1'b1;
        end else begin
            m_data = b;
            m_rdf  = 1'b1;
            m_rdc++;
        end
    endfunction

    task automatic drive(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop,
                              input logic par);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(b[i], BIT);
`ifdef UART_RX_PARITY_EN
        drive(par, BIT);
`else
        if (par === 1'bx) rxd = 1'b1;
`endif
        if (stop) begin
            drive(1'b1, BIT);
        end else begin
            drive(1'b0, LOW_STP);
            drive(1'b1, BIT - LOW_STP);
        end
    endtask

    task automatic do_read();
        @(negedge clk) rd = 1'b1;
        @(negedge clk) rd = 1'b0;
        m_rdf = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, "_rst_data"}, 32'(data), 32'h0);
        check({tag, "_rst_flags"}, 32'({rdf, rdc, error}), 32'h0);
        @(negedge clk) rst = 1'b0;
        m_data = 8'h00;
        m_rdf  = 1'b0;
        m_err  = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        bit         stop;

        do_reset("init");
        check("init_state", 32'(dut.state), 32'(IDLE));
        drive(1'b1, 20);

        send_frame(8'hA5, 1'b1, ^8'hA5);
        m_frame(8'hA5, 1'b1, 1'b1);
        drive(1'b1, 16);
        check_all("a5");
        do_read();
        check("a5_read_rdf", 32'(rdf), 32'(m_rdf));

        drive(1'b0, 20);
        drive(1'b1, BIT);
        check("false_rdf", 32'(rdf), 32'h0);
        check("false_err", 32'(error), 32'h0);
        check("false_rdc", 32'(rdc_cnt), 32'(m_rdc));
        check("false_state", 32'(dut.state), 32'(IDLE));

        do_reset("fr");
        send_frame(8'h3C, 1'b0, ^8'h3C);
        m_frame(8'h3C, 1'b0, 1'b1);
        drive(1'b1, 2 * BIT);
        check_all("frame_err");
        do_read();
        check("frame_err_clr", 32'(error), 32'(m_err));

        send_frame(8'h11, 1'b1, ^8'h11);
        m_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, ^8'h22);
        m_frame(8'h22, 1'b1, 1'b1);
        drive(1'b1, 16);
        check_all("overrun");
        do_read();
        check_all("overrun_rd");

        do_reset("mid");
        drive(1'b0, BIT);
        drive(1'b1, 4 * BIT + BIT / 2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_data = 8'h00;
        m_rdf  = 1'b0;
        m_err  = 1'b0;
        drive(1'b1, BIT / 2 + 4 * BIT);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        m_frame(8'h5A, 1'b1, 1'b1);
        drive(1'b1, 16);
        check_all("mid_rst");
        do_read();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1);
        m_frame(8'h03, 1'b1, 1'b0);
        drive(1'b1, 16);
        check_all("par_bad");
        do_read();
        send_frame(8'h03, 1'b1, 1'b0);
        m_frame(8'h03, 1'b1, 1'b1);
        drive(1'b1, 16);
        check_all("par_good");
        do_read();
`endif

        for (int i = 0; i < 14; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            send_frame(b, stop, ^b);
            m_frame(b, stop, 1'b1);
            if (!stop) begin
                drive(1'b1, 2 * BIT);
            end else if ($urandom_range(0, 1) == 1) begin
                drive(1'b1, 16);
            end
            if (stop || $urandom_range(0, 1) == 1) begin
                drive(1'b1, 4);
                check_all($sformatf("rnd%0d", i));
            end
            if ($urandom_range(0, 2) != 0) begin
                drive(1'b1, 4);
                do_read();
                check($sformatf("rnd%0d_rd_rdf", i), 32'(rdf), 32'(m_rdf));
                check($sformatf("rnd%0d_rd_err", i), 32'(error), 32'(m_err));
            end
        end

        drive(1'b1, 16);
        check_all("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
